fifo_bit_packer: RTL and testbench
==================================

Name: fifo_bit_packer

Overview:
- Downstream consumer of the 1-bit FIFO in the MicroEV20 micro.
- Drains head bits from the FIFO and packs WORD_W consecutive bits into a parallel word.
- Presents each completed word to the next stage over a valid/ready handshake.
- Owns the FIFO's pop and clear controls; exposes a flush request to the control unit.

Parameters:
- WORD_W, 8: bits per packed word (≥2).
- CNT_W, $clog2(WORD_W+1): width of bit_count.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_p  input  1  FIFO head bit (FIFO output P); valid only when fifo_size=1.
- fifo_size  input  1  FIFO non-empty flag (FIFO output size).
- fifo_pop  output  1  pop request to FIFO; combinational.
- fifo_clear  output  1  clear request to FIFO; combinational.
- flush  input  1  abort partial word and empty FIFO.
- word  output  WORD_W  packed word; first-popped bit in MSB.
- word_valid  output  1  word holds a complete packed word.
- word_ready  input  1  downstream accepts word.
- bit_count  output  CNT_W  bits collected into the current word.
- parity_err  output  1  parity check result for the presented word (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state=COLLECT, word=0, word_valid=0, bit_count=0, parity_err=0, fifo_pop=0.
- While rst_n=0, fifo_clear=1. The FIFO has no reset, so any clk edge during reset empties it.
- States: COLLECT, PARITY (macro only), HOLD.
- COLLECT:
  - fifo_pop = fifo_size & ~flush.
  - On each edge with fifo_pop=1: word <= {word[WORD_W-2:0], fifo_p}; bit_count++.
  - fifo_p is sampled on the same edge that pops it. The FIFO shifts on that edge, so back-to-back pops every cycle are legal; no bubble.
  - fifo_size=0: stall, no pop, state held.
  - The pop that brings bit_count to WORD_W moves to HOLD (or PARITY). word_valid=1 from the next cycle.
- HOLD:
  - fifo_pop=0.
  - word and word_valid stable until word_valid & word_ready at a posedge.
  - On that transfer: word_valid<=0, bit_count<=0, state<=COLLECT. Popping resumes the following cycle, so minimum spacing between words is WORD_W+1 cycles.
- word is not cleared after transfer; it is overwritten by shifting. Downstream must qualify word with word_valid.
- flush=1 (any state):
  - fifo_clear=1 and fifo_pop=0 that cycle.
  - Next edge: bit_count=0, word=0, word_valid=0, parity_err=0, state=COLLECT.
  - If flush coincides with word_valid & word_ready, the handshake completes (word counts as delivered), then the flush takes effect.
- fifo_clear=0 at all other times. The block never asserts push.
- Latency: a bit present at the FIFO head with an idle packer is popped in the same cycle. The word is valid 1 cycle after its last pop (2 cycles with parity).

Optional Feature:
- Macro: FIFO_BIT_PACKER_PARITY_EN.
- Defined:
  - After the WORD_W data bits, state PARITY pops one more bit (same fifo_size stall rule), which is an even-parity bit.
  - On that pop: parity_err <= ^word ^ fifo_p, state <= HOLD.
  - parity_err is valid with word_valid and clears on transfer, flush and reset.
- Not defined:
  - PARITY state and logic absent; COLLECT goes straight to HOLD.
  - parity_err tied to 0.
  - Port list is identical in both builds.

Test Plan:
- Reset hold: rst_n=0 across 2 edges with FIFO holding 1,1 -> fifo_clear=1 throughout; after release fifo_size=0, word_valid=0, bit_count=0.
- Basic pack, WORD_W=8: FIFO fed 1,0,1,1,0,0,1,0 as fast as possible, word_ready=1 -> 8 consecutive pop cycles; word=8'hB2, word_valid high for exactly 1 cycle.
- Starvation and backpressure: bits arrive one every 3 cycles -> pop only when fifo_size=1, bit_count steps 1..8. Then word_ready=0 for 5 cycles -> word=8'hB2 stable, fifo_pop=0 throughout HOLD.
- Flush mid-word: flush after 5 bits -> fifo_clear=1 for that cycle, bit_count=0, word_valid never asserted. The next 8 bits 1,1,1,1,0,0,0,0 -> word=8'hF0.
- Flush during HOLD with word_ready=1 -> exactly one transfer seen; next cycle word_valid=0, state COLLECT.
- Parity (macro defined): 0xB2 followed by parity bit 0 -> parity_err=0; followed by parity bit 1 -> parity_err=1. word_valid is asserted 1 cycle after the 9th pop in both cases.

Source files
------------

// File: rtl/fifo_bit_packer.sv
// Drains a 1-bit FIFO and packs WORD_W bits (first-popped in MSB) into a word offered on
// a valid/ready handshake. Define FIFO_BIT_PACKER_PARITY_EN to pop and check a trailing even-parity bit.
module fifo_bit_packer #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_p,
    input  logic              fifo_size,
    output logic              fifo_pop,
    output logic              fifo_clear,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  bit_count,
    output logic              parity_err
);

    typedef enum logic [1:0] {StCollect, StParity, StHold} state_e;

    state_e             state_q;
    logic [WORD_W-1:0]  word_q;
    logic               valid_q;
    logic [CNT_W-1:0]   count_q;
    logic               last_bit;

    // The FIFO has no reset of its own, so it is held clear while we are in reset.
    assign fifo_clear = ~rst_n | flush;
    assign fifo_pop   = rst_n & ~flush & fifo_size & (state_q != StHold);
    assign last_bit   = (count_q == CNT_W'(WORD_W - 1));

    assign word       = word_q;
    assign word_valid = valid_q;
    assign bit_count  = count_q;

`ifdef FIFO_BIT_PACKER_PARITY_EN
    logic parity_q;
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StCollect;
            word_q   <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
`ifdef FIFO_BIT_PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (flush) begin
            // A handshake in the same cycle still completes; clearing valid here retires it.
            state_q  <= StCollect;
            word_q   <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
`ifdef FIFO_BIT_PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StCollect: begin
                    if (fifo_pop) begin
                        word_q  <= {word_q[WORD_W-2:0], fifo_p};
                        count_q <= count_q + CNT_W'(1);
                        if (last_bit) begin
`ifdef FIFO_BIT_PACKER_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StHold;
                            valid_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FIFO_BIT_PACKER_PARITY_EN
                StParity: begin
                    if (fifo_pop) begin
                        parity_q <= ^word_q ^ fifo_p;
                        valid_q  <= 1'b1;
                        state_q  <= StHold;
                    end
                end
`endif
                StHold: begin
                    if (word_ready) begin
                        valid_q  <= 1'b0;
                        count_q  <= '0;
                        state_q  <= StCollect;
`ifdef FIFO_BIT_PACKER_PARITY_EN
                        parity_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_bit_packer.sv
// Bench for fifo_bit_packer: a queue models the 1-bit FIFO; expected words go to a
// scoreboard that a negedge monitor drains on each valid&ready transfer.
module tb_fifo_bit_packer;

    localparam int unsigned WW = 8;
    localparam int unsigned CW = $clog2(WW + 1);
`ifdef FIFO_BIT_PACKER_PARITY_EN
    localparam int unsigned NB = WW + 1;
`else
    localparam int unsigned NB = WW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_p = 1'b0;
    logic          fifo_size = 1'b0;
    logic          fifo_pop;
    logic          fifo_clear;
    logic          flush = 1'b0;
    logic [WW-1:0] word;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [CW-1:0] bit_count;
    logic          parity_err;

    fifo_bit_packer #(.WORD_W(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_p     (fifo_p),
        .fifo_size  (fifo_size),
        .fifo_pop   (fifo_pop),
        .fifo_clear (fifo_clear),
        .flush      (flush),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_count  (bit_count),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pops = 0;
    int n_xfer = 0;
    int valid_cycles = 0;
    logic          fq[$];
    logic [WW-1:0] exp_word[$];
    logic          exp_par[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd();
        fifo_size = (fq.size() != 0);
        fifo_p    = (fq.size() != 0) ? fq[0] : 1'b0;
    endtask

    // One clock: controls sampled at negedge, FIFO model updated just after posedge.
    task automatic tick();
        logic pop_c;
        logic clr_c;
        @(negedge clk);
        pop_c = fifo_pop;
        clr_c = fifo_clear;
        @(posedge clk);
        #1;
        if (clr_c) fq.delete();
        else if (pop_c) begin
            void'(fq.pop_front());
            n_pops++;
        end
        upd();
    endtask

    function automatic logic exp_parity(input logic [WW-1:0] w, input logic pb);
`ifdef FIFO_BIT_PACKER_PARITY_EN
        return (^w) ^ pb;
`else
        return 1'b0 & pb & w[0];
`endif
    endfunction

    task automatic push_word(input logic [WW-1:0] w, input logic pb, input bit expect_it);
        for (int i = WW - 1; i >= 0; i--) fq.push_back(w[i]);
`ifdef FIFO_BIT_PACKER_PARITY_EN
        fq.push_back(pb);
`endif
        if (expect_it) begin
            exp_word.push_back(w);
            exp_par.push_back(exp_parity(w, pb));
        end
        upd();
    endtask

    always @(negedge clk) begin
        if (rst_n && word_valid) begin
            valid_cycles++;
            if (word_ready) begin
                n_xfer++;
                if (exp_word.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", word, $time);
                end else begin
                    check("sb_word", 32'(word), 32'(exp_word.pop_front()));
                    check("sb_parity_err", 32'(parity_err), 32'(exp_par.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int v0;
        int x0;
        logic [WW-1:0] b2;
        b2 = 8'hB2;

        // Reset hold with FIFO holding 1,1
        fq.push_back(1'b1);
        fq.push_back(1'b1);
        upd();
        #1;
        check("rst_clear", 32'(fifo_clear), 1);
        check("rst_pop", 32'(fifo_pop), 0);
        tick();
        check("rst_clear2", 32'(fifo_clear), 1);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_fifo_size", 32'(fifo_size), 0);
        check("rst_valid", 32'(word_valid), 0);
        check("rst_count", 32'(bit_count), 0);
        check("rst_fifo_clear_off", 32'(fifo_clear), 0);
        check("rst_parity", 32'(parity_err), 0);

        // Basic pack at full rate
        word_ready = 1'b1;
        p0 = n_pops;
        v0 = valid_cycles;
        push_word(b2, 1'b0, 1'b1);
        for (int i = 0; i < NB; i++) tick();
        check("basic_pops", 32'(n_pops - p0), 32'(NB));
        check("basic_valid", 32'(word_valid), 1);
        check("basic_word", 32'(word), 32'hB2);
        tick();
        check("basic_valid_drop", 32'(word_valid), 0);
        check("basic_count_zero", 32'(bit_count), 0);
        check("basic_valid_cycles", 32'(valid_cycles - v0), 1);

        // Starvation then backpressure
        word_ready = 1'b0;
        p0 = n_pops;
        exp_word.push_back(b2);
        exp_par.push_back(exp_parity(b2, 1'b0));
        for (int i = 0; i < NB; i++) begin
            fq.push_back((i < WW) ? b2[WW-1-i] : 1'b0);
            upd();
            tick();
            check("starve_count", 32'(bit_count), (i < WW) ? 32'(i + 1) : 32'(WW));
            tick();
            tick();
            check("starve_pops", 32'(n_pops - p0), 32'(i + 1));
        end
        fq.push_back(1'b1);
        upd();
        p0 = n_pops;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_word", 32'(word), 32'hB2);
            check("hold_valid", 32'(word_valid), 1);
        end
        check("hold_no_pop", 32'(n_pops - p0), 0);
        word_ready = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        check("flush_idle_clear", 32'(fifo_clear), 1);
        check("flush_idle_pop", 32'(fifo_pop), 0);
        tick();
        flush = 1'b0;
        check("flush_idle_fifo", 32'(fifo_size), 0);
        check("flush_idle_count", 32'(bit_count), 0);

        // Flush mid-word
        v0 = valid_cycles;
        for (int i = 0; i < 5; i++) fq.push_back(1'(i % 2 == 0));
        upd();
        for (int i = 0; i < 5; i++) tick();
        check("mid_count5", 32'(bit_count), 5);
        flush = 1'b1;
        #1;
        check("mid_flush_clear", 32'(fifo_clear), 1);
        tick();
        flush = 1'b0;
        check("mid_count0", 32'(bit_count), 0);
        check("mid_word0", 32'(word), 0);
        check("mid_no_valid", 32'(valid_cycles - v0), 0);
        push_word(8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < NB; i++) tick();
        check("mid_f0_word", 32'(word), 32'hF0);
        tick();

        // Flush in HOLD coinciding with a transfer
        word_ready = 1'b0;
        push_word(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < NB; i++) tick();
        check("hf_valid", 32'(word_valid), 1);
        check("hf_parity", 32'(parity_err), 32'(exp_parity(8'h5A, 1'b1)));
        x0 = n_xfer;
        word_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("hf_valid_off", 32'(word_valid), 0);
        check("hf_count", 32'(bit_count), 0);
        check("hf_parity_off", 32'(parity_err), 0);
        tick();
        check("hf_xfers", 32'(n_xfer - x0), 1);

        // Parity bit 1 on 0xB2
        push_word(b2, 1'b1, 1'b1);
        for (int i = 0; i < NB; i++) tick();
        check("par_valid", 32'(word_valid), 1);
        check("par_err", 32'(parity_err), 32'(exp_parity(b2, 1'b1)));
        tick();
        tick();

        check("sb_empty", 32'(exp_word.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
